sec_min_stopwatch: RTL and testbench
====================================

SEC_MIN_STOPWATCH -- requirements
Module: sec_min_stopwatch

Interface
REQ-001 Parameter SAT, default 0, 0 = wrap 59:59->00:00, 1 = saturate at 59:59 and stop.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ce  input  1  one-second tick, exactly one clk wide, synchronous to clk.
REQ-005 start_stop  input  1  single-cycle command pulse, synchronous to clk.
REQ-006 clr  input  1  single-cycle clear pulse, synchronous to clk.
REQ-007 lap  input  1  single-cycle lap-freeze toggle pulse, synchronous to clk.
REQ-008 sec_lo  output  4  displayed seconds units, BCD 0-9.
REQ-009 sec_hi  output  4  displayed seconds tens, BCD 0-5.
REQ-010 min_lo  output  4  displayed minutes units, BCD 0-9.
REQ-011 min_hi  output  4  displayed minutes tens, BCD 0-5.
REQ-012 running  output  1  high while state = RUN.
REQ-013 lap_active  output  1  high while the display is frozen.
REQ-014 ovf  output  1  one-clk pulse on the 59:59 boundary tick.

Function
REQ-015 FSM states IDLE, RUN, STOP; the internal count is a 4-digit BCD register independent of the display.
REQ-016 IDLE: count = 00:00; start_stop -> RUN; clr -> no-op (stay IDLE).
REQ-017 RUN: start_stop -> STOP; clr ignored.
REQ-018 STOP: start_stop -> RUN; clr -> IDLE with count = 00:00.
REQ-019 Simultaneous start_stop and clr in STOP: clr wins, next state IDLE, count 00:00; in IDLE: start_stop wins, next state RUN, count 00:00.
REQ-020 Count increments by one second only while state = RUN and ce = 1; new value visible on the edge where ce is sampled (latency 1 clk).
REQ-021 ce in the same cycle as start_stop in RUN: the tick is counted, then STOP; ce in the same cycle as start_stop in IDLE or STOP: the tick is not counted.
REQ-022 Digit carry: sec_lo 9->0 carries to sec_hi; sec_hi 5->0 carries to min_lo; min_lo 9->0 carries to min_hi; min_hi 5->0 is the boundary; no digit ever leaves its BCD range.
REQ-023 SAT = 0: tick at 59:59 -> count 00:00, ovf = 1 for one clk, state stays RUN.
REQ-024 SAT = 1: tick at 59:59 -> count holds 59:59, ovf = 1 for one clk, state -> STOP; further start_stop -> RUN, and subsequent ticks hold 59:59 without new ovf until clr.
REQ-025 lap in RUN with lap_active = 0: capture count (including any same-cycle increment) into a lap register, lap_active -> 1.
REQ-026 lap in RUN with lap_active = 1: lap_active -> 0; display returns to the live count on the next clk.
REQ-027 lap in IDLE or STOP: lap_active -> 0.
REQ-028 clr accepted (STOP -> IDLE) also forces lap_active -> 0.
REQ-029 Display digits = lap register when lap_active = 1, otherwise live count; counting continues internally while frozen.
REQ-030 Outputs are registered or a pure function of registered state; no combinational path from inputs to outputs.

Reset
REQ-031 rst = 1 forces immediately, regardless of clk: state IDLE, count 00:00, lap register 00:00, all digits 0, running = 0, lap_active = 0, ovf = 0.
REQ-032 rst asserted mid-RUN or mid-ovf pulse aborts the operation; after release the block waits in IDLE for start_stop.
REQ-033 Inputs are ignored while rst = 1.

Verification
REQ-034 Reset, start_stop, 75 ce pulses -> display 01:15, running = 1, ovf never asserted.
REQ-035 SAT = 0, count preset by 3599 ticks, one more ce -> display 00:00, ovf high exactly 1 clk, running = 1.
REQ-036 SAT = 1, 3600 ticks -> display 59:59, ovf 1 clk, running = 0; start_stop plus 5 ticks -> still 59:59, no ovf.
REQ-037 RUN at 00:10, lap, 20 ticks -> display 00:10, lap_active = 1; lap again -> display 00:30 next clk.
REQ-038 STOP at 00:42, start_stop and clr same cycle -> IDLE, display 00:00, running = 0; RUN with clr pulse -> ignored, count unchanged.
REQ-039 RUN, start_stop coincident with ce at 00:07 -> STOP, display 00:08; rst mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sec_min_stopwatch.sv
// ============================================================================
// Module  : sec_min_stopwatch
// Brief   : MM:SS BCD stopwatch with start/stop, clear, lap freeze and
//           wrap-or-saturate behaviour at 59:59.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sec_min_stopwatch #(
    parameter bit SAT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       start_stop,
    input  logic       clr,
    input  logic       lap,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic       running,
    output logic       lap_active,
    output logic       ovf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    // Digits packed as {min_hi, min_lo, sec_hi, sec_lo}
    logic [1:0]  state, state_nxt;
    logic [15:0] cnt, cnt_nxt, cnt_inc;
    logic [15:0] lap_cnt, lap_cnt_nxt;
    logic        lap_active_nxt;
    logic        ovf_nxt;
    logic        sat_hold, sat_hold_nxt;
    logic        tick;
    logic        at_max;

    assign tick   = (state == RUN) && ce;
    assign at_max = (cnt == 16'h5959);

    // BCD ripple increment; 59:59 naturally rolls to 00:00
    always_comb begin
        cnt_inc = cnt;
        if (cnt[3:0] != 4'd9) begin
            cnt_inc[3:0] = cnt[3:0] + 4'd1;
        end else begin
            cnt_inc[3:0] = 4'd0;
            if (cnt[7:4] != 4'd5) begin
                cnt_inc[7:4] = cnt[7:4] + 4'd1;
            end else begin
                cnt_inc[7:4] = 4'd0;
                if (cnt[11:8] != 4'd9) begin
                    cnt_inc[11:8] = cnt[11:8] + 4'd1;
                end else begin
                    cnt_inc[11:8] = 4'd0;
                    if (cnt[15:12] != 4'd5) begin
                        cnt_inc[15:12] = cnt[15:12] + 4'd1;
                    end else begin
                        cnt_inc[15:12] = 4'd0;
                    end
                end
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        lap_cnt_nxt    = lap_cnt;
        lap_active_nxt = lap_active;
        ovf_nxt        = 1'b0;
        sat_hold_nxt   = sat_hold;
        case (state)
            IDLE: begin
                cnt_nxt = 16'h0000;
                if (start_stop) state_nxt = RUN;
                if (lap)        lap_active_nxt = 1'b0;
            end
            RUN: begin
                if (tick) begin
                    if (!at_max) begin
                        cnt_nxt = cnt_inc;
                    end else if (!SAT) begin
                        cnt_nxt = cnt_inc;
                        ovf_nxt = 1'b1;
                    end else if (!sat_hold) begin
                        // Saturate once: flag, stop, and hold 59:59 until cleared
                        ovf_nxt      = 1'b1;
                        sat_hold_nxt = 1'b1;
                        state_nxt    = STOP;
                    end
                end
                if (start_stop) state_nxt = STOP;
                if (lap) begin
                    if (lap_active) begin
                        lap_active_nxt = 1'b0;
                    end else begin
                        lap_cnt_nxt    = cnt_nxt;
                        lap_active_nxt = 1'b1;
                    end
                end
            end
            STOP: begin
                if (lap) lap_active_nxt = 1'b0;
                if (clr) begin
                    state_nxt      = IDLE;
                    cnt_nxt        = 16'h0000;
                    lap_active_nxt = 1'b0;
                    sat_hold_nxt   = 1'b0;
                end else if (start_stop) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 16'h0000;
            lap_cnt    <= 16'h0000;
            lap_active <= 1'b0;
            ovf        <= 1'b0;
            sat_hold   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            lap_cnt    <= lap_cnt_nxt;
            lap_active <= lap_active_nxt;
            ovf        <= ovf_nxt;
            sat_hold   <= sat_hold_nxt;
        end
    end

    assign {min_hi, min_lo, sec_hi, sec_lo} = lap_active ? lap_cnt : cnt;
    assign running = (state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_sec_min_stopwatch.sv
// ============================================================================
// Module  : tb_sec_min_stopwatch
// Brief   : Directed self-checking bench; one wrapping and one saturating
//           instance share the same stimulus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sec_min_stopwatch;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce = 1'b0;
    logic start_stop = 1'b0;
    logic clr = 1'b0;
    logic lap = 1'b0;

    logic [3:0] sl0, sh0, ml0, mh0, sl1, sh1, ml1, mh1;
    logic       run0, run1, la0, la1, ovf0, ovf1;
    logic [15:0] disp0, disp1;

    int errors = 0;
    int checks = 0;
    int ovf0_n = 0;
    int ovf1_n = 0;

    assign disp0 = {mh0, ml0, sh0, sl0};
    assign disp1 = {mh1, ml1, sh1, sl1};

    always #5 clk = ~clk;

    sec_min_stopwatch #(.SAT(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .ce(ce), .start_stop(start_stop), .clr(clr), .lap(lap),
        .sec_lo(sl0), .sec_hi(sh0), .min_lo(ml0), .min_hi(mh0),
        .running(run0), .lap_active(la0), .ovf(ovf0)
    );

    sec_min_stopwatch #(.SAT(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .ce(ce), .start_stop(start_stop), .clr(clr), .lap(lap),
        .sec_lo(sl1), .sec_hi(sh1), .min_lo(ml1), .min_hi(mh1),
        .running(run1), .lap_active(la1), .ovf(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive for one clock, return at the following negedge
    task automatic pulse(input logic ss, input logic cl, input logic lp, input logic c);
        start_stop = ss; clr = cl; lap = lp; ce = c;
        @(negedge clk);
        start_stop = 1'b0; clr = 1'b0; lap = 1'b0; ce = 1'b0;
        if (ovf0) ovf0_n++;
        if (ovf1) ovf1_n++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ovf0_n = 0;
        ovf1_n = 0;
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_disp", disp0, 16'h0000);
        check("rst_running", run0, 1'b0);
        check("rst_lap_active", la0, 1'b0);
        check("rst_ovf", ovf0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic counting
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(75);
        check("count75_disp", disp0, 16'h0115);
        check("count75_running", run0, 1'b1);
        check("count75_no_ovf", ovf0_n, 0);

        // Boundary: wrap vs saturate
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3599);
        check("pre_max_wrap", disp0, 16'h5959);
        check("pre_max_sat", disp1, 16'h5959);
        check("pre_max_no_ovf", ovf0_n + ovf1_n, 0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("wrap_disp", disp0, 16'h0000);
        check("wrap_ovf", ovf0, 1'b1);
        check("wrap_running", run0, 1'b1);
        check("sat_disp", disp1, 16'h5959);
        check("sat_ovf", ovf1, 1'b1);
        check("sat_running", run1, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap_ovf_one_clk", ovf0, 1'b0);
        check("sat_ovf_one_clk", ovf1, 1'b0);
        ovf1_n = 0;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_restart_running", run1, 1'b1);
        ticks(5);
        check("sat_hold_disp", disp1, 16'h5959);
        check("sat_hold_no_ovf", ovf1_n, 0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("sat_clr_disp", disp1, 16'h0000);
        check("sat_clr_running", run1, 1'b0);

        // Lap freeze
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(10);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("lap_on_active", la0, 1'b1);
        ticks(20);
        check("lap_frozen_disp", disp0, 16'h0010);
        check("lap_frozen_active", la0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("lap_off_disp", disp0, 16'h0030);
        check("lap_off_active", la0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        check("lap_with_tick_disp", disp0, 16'h0031);
        ticks(2);
        check("lap_with_tick_frozen", disp0, 16'h0031);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("lap_in_stop_clears", la0, 1'b0);
        check("lap_in_stop_disp", disp0, 16'h0033);

        // Clear priority and clr ignored in RUN
        do_reset();
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_clr_noop", run0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b1);
        check("idle_ss_clr_running", run0, 1'b1);
        check("idle_ss_ce_not_counted", disp0, 16'h0000);
        ticks(42);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("stop42_disp", disp0, 16'h0042);
        check("stop42_running", run0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check("stop_ss_clr_disp", disp0, 16'h0000);
        check("stop_ss_clr_running", run0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("run_clr_ignored_disp", disp0, 16'h0003);
        check("run_clr_ignored_running", run0, 1'b1);

        // start_stop coincident with ce, then async reset mid-RUN
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(7);
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        check("ss_ce_run_disp", disp0, 16'h0008);
        check("ss_ce_run_running", run0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        check("ss_ce_stop_disp", disp0, 16'h0008);
        check("ss_ce_stop_running", run0, 1'b1);
        ticks(4);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("pre_rst_lap_active", la0, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_disp", disp0, 16'h0000);
        check("async_rst_running", run0, 1'b0);
        check("async_rst_lap_active", la0, 1'b0);
        check("async_rst_ovf", ovf0, 1'b0);
        @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        ticks(3);
        check("post_rst_idle_disp", disp0, 16'h0000);
        check("post_rst_idle_running", run0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
